// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states,
// opcodes, datapath mux/ALU encodings and small opcode classifiers.
package mc_ctrl_pkg;

   typedef enum logic [4:0] {
      S_FETCH   = 5'd0,
      S_DECODE  = 5'd1,
      S_MEMADR  = 5'd2,
      S_MEMRD   = 5'd3,
      S_MEMWB   = 5'd4,
      S_MEMWR   = 5'd5,
      S_RTYPEEX = 5'd6,
      S_RTYPEWB = 5'd7,
      S_BEQEX   = 5'd8,
      S_BNEEX   = 5'd9,
      S_IMMEX   = 5'd10,
      S_IMMWB   = 5'd11,
      S_JEX     = 5'd12,
      S_JALEX   = 5'd13,
      S_FAULT   = 5'd14
   } statetype;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALU operation requests to the ALU decoder
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   // ALU B-operand select
   localparam logic [2:0] SRCB_B     = 3'b000;
   localparam logic [2:0] SRCB_FOUR  = 3'b001;
   localparam logic [2:0] SRCB_SIMM  = 3'b010;
   localparam logic [2:0] SRCB_SIMM2 = 3'b011;
   localparam logic [2:0] SRCB_ZIMM  = 3'b100;

   // Next-PC select
   localparam logic [1:0] PC_ALURES = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // Register write-back data select
   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_DATA   = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;

   // Destination register select
   localparam logic [1:0] RD_RT  = 2'b00;
   localparam logic [1:0] RD_RD  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   // Load extraction / extension
   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_BU = 3'b001;
   localparam logic [2:0] LD_B  = 3'b010;
   localparam logic [2:0] LD_HU = 3'b011;
   localparam logic [2:0] LD_H  = 3'b100;

   // Store lane width
   localparam logic [1:0] ST_W = 2'b00;
   localparam logic [1:0] ST_B = 2'b01;
   localparam logic [1:0] ST_H = 2'b10;

   // State following DECODE; S_FETCH means the opcode is not decodable.
   function automatic statetype decode_target(input logic [5:0] op, input logic half_en);
      statetype t;
      t = S_FETCH;
      case (op)
         OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: t = S_MEMADR;
         OP_LH, OP_LHU, OP_SH:               t = half_en ? S_MEMADR : S_FETCH;
         OP_RTYPE:                           t = S_RTYPEEX;
         OP_BEQ:                             t = S_BEQEX;
         OP_BNE:                             t = S_BNEEX;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  t = S_IMMEX;
         OP_J:                               t = S_JEX;
         OP_JAL:                             t = S_JALEX;
         default:                            t = S_FETCH;
      endcase
      return t;
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
   endfunction

   function automatic logic [2:0] ldsize_of(input logic [5:0] op);
      logic [2:0] s;
      case (op)
         OP_LBU:  s = LD_BU;
         OP_LB:   s = LD_B;
         OP_LHU:  s = LD_HU;
         OP_LH:   s = LD_H;
         default: s = LD_W;
      endcase
      return s;
   endfunction

   function automatic logic [1:0] stsize_of(input logic [5:0] op);
      logic [1:0] s;
      case (op)
         OP_SB:   s = ST_B;
         OP_SH:   s = ST_H;
         default: s = ST_W;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter. Counts consecutive not-ready cycles spent in
// one memory state and flags the cycle after which the FSM must give up.
module mc_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 15,
   parameter int unsigned TO_W           = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wait_i,     // in a memory state and memory not ready
   input  logic stay_i,     // FSM keeps its current state next cycle
   output logic expired_o   // this not-ready cycle is the last one allowed
);

   localparam logic [TO_W-1:0] LAST    = (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] CNT_MAX = '1;

   logic [TO_W-1:0] cnt_q, cnt_d;

   // Count while waiting in the same state; saturate so a disabled timeout never wraps.
   always_comb begin
      cnt_d = '0;
      if (wait_i && stay_i) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TO_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (TIMEOUT_CYCLES != 0) && wait_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_maindec_v2.sv
// Multicycle MIPS main control FSM with memory ready handshake, wait-state
// timeout fault, halfword/byte memory ops, ORI/SLTI/JAL and illegal-op flag.
module mc_maindec_v2
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_HANDSHAKE  = 1,
   parameter int unsigned SUPPORT_HALF   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 15,
   parameter int unsigned TO_W           = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       pcwrite,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       branch,
   output logic       bne,
   output logic       iord,
   output logic       alusrca,
   output logic [2:0] alusrcb,
   output logic [1:0] regdst,
   output logic [1:0] wbsel,
   output logic [1:0] pcsrc,
   output logic [2:0] aluop,
   output logic [2:0] ldsize,
   output logic [1:0] stsize,
   output logic       illegal,
   output logic       mem_fault,
   output logic [4:0] state_o
);

   statetype state_q, state_d;
   logic     rdy_eff;
   logic     in_mem_state;
   logic     waiting;
   logic     timeout;
   logic     stay;
   logic     half_en;

   // Without the handshake every access completes in one cycle, as in the legacy decoder.
   assign rdy_eff      = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign half_en      = (SUPPORT_HALF != 0);
   assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign waiting      = in_mem_state && !rdy_eff;
   assign stay         = (state_d == state_q);

   mc_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (reset),
      .wait_i    (waiting),
      .stay_i    (stay),
      .expired_o (timeout)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; timeout only fires when not ready, so a late ready always wins.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (timeout)      state_d = S_FAULT;
            else if (rdy_eff) state_d = S_DECODE;
         end
         S_DECODE:  state_d = decode_target(op, half_en);
         S_MEMADR:  state_d = is_store(op) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (timeout)      state_d = S_FAULT;
            else if (rdy_eff) state_d = S_MEMWB;
         end
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR: begin
            if (timeout)      state_d = S_FAULT;
            else if (rdy_eff) state_d = S_FETCH;
         end
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_RTYPEWB: state_d = S_FETCH;
         S_BEQEX:   state_d = S_FETCH;
         S_BNEEX:   state_d = S_FETCH;
         S_IMMEX:   state_d = S_IMMWB;
         S_IMMWB:   state_d = S_FETCH;
         S_JEX:     state_d = S_FETCH;
         S_JALEX:   state_d = S_FETCH;
         S_FAULT:   state_d = S_FAULT;
         default:   state_d = S_FETCH;
      endcase
   end

   // Output decode; write enables and the illegal pulse are masked while reset is low.
   always_comb begin
      mem_req   = 1'b0;
      pcwrite   = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      branch    = 1'b0;
      bne       = 1'b0;
      iord      = 1'b0;
      alusrca   = 1'b0;
      alusrcb   = SRCB_B;
      regdst    = RD_RT;
      wbsel     = WB_ALUOUT;
      pcsrc     = PC_ALURES;
      aluop     = ALU_ADD;
      ldsize    = LD_W;
      stsize    = ST_W;
      illegal   = 1'b0;
      mem_fault = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = rdy_eff;
            pcwrite = rdy_eff;
         end
         S_DECODE: begin
            alusrcb = SRCB_SIMM2;
            illegal = (decode_target(op, half_en) == S_FETCH);
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_SIMM;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            mem_req = 1'b1;
            ldsize  = ldsize_of(op);
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            wbsel    = WB_DATA;
            regdst   = RD_RT;
            ldsize   = ldsize_of(op);
         end
         S_MEMWR: begin
            iord     = 1'b1;
            mem_req  = 1'b1;
            stsize   = stsize_of(op);
            memwrite = rdy_eff;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALU_FUNCT;
         end
         S_RTYPEWB: begin
            regwrite = 1'b1;
            regdst   = RD_RD;
         end
         S_BEQEX, S_BNEEX: begin
            alusrca = 1'b1;
            aluop   = ALU_SUB;
            pcsrc   = PC_ALUOUT;
            branch  = (state_q == S_BEQEX);
            bne     = (state_q == S_BNEEX);
         end
         S_IMMEX: begin
            alusrca = 1'b1;
            case (op)
               OP_SLTI: begin alusrcb = SRCB_SIMM; aluop = ALU_SLT; end
               OP_ANDI: begin alusrcb = SRCB_ZIMM; aluop = ALU_AND; end
               OP_ORI:  begin alusrcb = SRCB_ZIMM; aluop = ALU_OR;  end
               default: begin alusrcb = SRCB_SIMM; aluop = ALU_ADD; end
            endcase
         end
         S_IMMWB: begin
            regwrite = 1'b1;
            regdst   = RD_RT;
         end
         S_JEX: begin
            pcwrite = 1'b1;
            pcsrc   = PC_JUMP;
         end
         S_JALEX: begin
            // PC already holds PC+4 here, so r31 receives the return address.
            pcwrite  = 1'b1;
            pcsrc    = PC_JUMP;
            regwrite = 1'b1;
            regdst   = RD_R31;
            wbsel    = WB_PC;
         end
         S_FAULT: begin
            mem_fault = 1'b1;
         end
         default: ;
      endcase
      if (!reset) begin
         pcwrite  = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
         memwrite = 1'b0;
         illegal  = 1'b0;
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_mc_maindec_v2.sv
// Scoreboard bench for mc_maindec_v2. Instance 0: default parameters.
// Instance 1: no handshake, no halfword support. An instruction-level model
// queues the expected control word per cycle; a monitor compares on negedge.
module tb_mc_maindec_v2;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] st;
    logic       mem_req, pcwrite, memwrite, irwrite, regwrite, branch, bne, iord, alusrca;
    logic [2:0] alusrcb;
    logic [1:0] regdst, wbsel, pcsrc;
    logic [2:0] aluop, ldsize;
    logic [1:0] stsize;
    logic       illegal, mem_fault;
  } ctl_t;

  typedef struct {
    bit   d;
    ctl_t c;
  } item_t;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_BEQ = 3, K_BNE = 4, K_IMM = 5, K_J = 6, K_JAL = 7;
  localparam int TO = 15;

  typedef struct {
    logic [5:0] op;
    int         kind;
    logic [2:0] sz;
    logic [2:0] srcb;
    logic [2:0] alu;
    bit         half;
  } ins_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;

  logic       mem_req_w[2], pcwrite_w[2], memwrite_w[2], irwrite_w[2], regwrite_w[2];
  logic       branch_w[2], bne_w[2], iord_w[2], alusrca_w[2], illegal_w[2], mem_fault_w[2];
  logic [2:0] alusrcb_w[2], aluop_w[2], ldsize_w[2];
  logic [1:0] regdst_w[2], wbsel_w[2], pcsrc_w[2], stsize_w[2];
  logic [4:0] state_w[2];
  ctl_t       act[2];

  item_t q[$];
  ins_t  tbl[$];
  int    compared = 0;
  int    mismatched = 0;
  int    stepno = 0;
  item_t mon_it;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mc_maindec_v2 #(
      .MEM_HANDSHAKE  ((g == 0) ? 1 : 0),
      .SUPPORT_HALF   ((g == 0) ? 1 : 0),
      .TIMEOUT_CYCLES (15),
      .TO_W           (4)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .mem_ready ((g == 0) ? mem_ready : 1'b0),
      .mem_req   (mem_req_w[g]),
      .pcwrite   (pcwrite_w[g]),
      .memwrite  (memwrite_w[g]),
      .irwrite   (irwrite_w[g]),
      .regwrite  (regwrite_w[g]),
      .branch    (branch_w[g]),
      .bne       (bne_w[g]),
      .iord      (iord_w[g]),
      .alusrca   (alusrca_w[g]),
      .alusrcb   (alusrcb_w[g]),
      .regdst    (regdst_w[g]),
      .wbsel     (wbsel_w[g]),
      .pcsrc     (pcsrc_w[g]),
      .aluop     (aluop_w[g]),
      .ldsize    (ldsize_w[g]),
      .stsize    (stsize_w[g]),
      .illegal   (illegal_w[g]),
      .mem_fault (mem_fault_w[g]),
      .state_o   (state_w[g])
    );
    assign act[g] = '{st: state_w[g], mem_req: mem_req_w[g], pcwrite: pcwrite_w[g],
                      memwrite: memwrite_w[g], irwrite: irwrite_w[g], regwrite: regwrite_w[g],
                      branch: branch_w[g], bne: bne_w[g], iord: iord_w[g], alusrca: alusrca_w[g],
                      alusrcb: alusrcb_w[g], regdst: regdst_w[g], wbsel: wbsel_w[g],
                      pcsrc: pcsrc_w[g], aluop: aluop_w[g], ldsize: ldsize_w[g],
                      stsize: stsize_w[g], illegal: illegal_w[g], mem_fault: mem_fault_w[g]};
  end

  // Monitor: one expected control word per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_it = q.pop_front();
      compared++;
      if (act[mon_it.d] !== mon_it.c) begin
        mismatched++;
        $display("FAIL ctl dut%0d step%0d: actual state=%0d word=%h required state=%0d word=%h",
                 mon_it.d, compared, act[mon_it.d].st, act[mon_it.d], mon_it.c.st, mon_it.c);
      end
    end
  end

  task automatic expect_now(input bit d, input string what, input logic ok);
    compared++;
    if (ok !== 1'b1) begin
      mismatched++;
      $display("FAIL %s dut%0d: state=%0d mem_fault=%b pcwrite=%b irwrite=%b regwrite=%b memwrite=%b",
               what, d, state_w[d], mem_fault_w[d], pcwrite_w[d], irwrite_w[d],
               regwrite_w[d], memwrite_w[d]);
    end
  endtask

  function automatic ctl_t blank(input statetype s);
    ctl_t c;
    c = '0;
    c.st = s;
    return c;
  endfunction

  function automatic ctl_t fetch_ctl();
    ctl_t c;
    c = blank(S_FETCH);
    c.mem_req = 1'b1;
    c.alusrcb = 3'b001;
    return c;
  endfunction

  function automatic int find(input logic [5:0] o);
    foreach (tbl[i]) if (tbl[i].op == o) return i;
    return -1;
  endfunction

  task automatic step(input bit d, input ctl_t c, input logic rdy);
    item_t it;
    mem_ready = rdy;
    it.d = d;
    it.c = c;
    q.push_back(it);
    stepno++;
    @(posedge clk);
    #1;
  endtask

  // Memory access left unanswered 'waits' cycles; reports whether the timeout hit.
  task automatic mem_wait(input bit d, input ctl_t c, input int waits, output bit faulted);
    int n;
    n = d ? 0 : waits;
    faulted = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(d, c, 1'b0);
      if (i + 1 == TO) begin
        faulted = 1'b1;
        return;
      end
    end
  endtask

  task automatic fault_tail(input bit d);
    ctl_t c;
    expect_now(d, "expired-wait", (state_w[d] == 5'(S_FAULT)) && (mem_fault_w[d] == 1'b1));
    c = blank(S_FAULT);
    c.mem_fault = 1'b1;
    for (int i = 0; i < 4; i++) step(d, c, 1'($urandom));
    expect_now(d, "sticky-fault", (state_w[d] == 5'(S_FAULT)) && (mem_fault_w[d] == 1'b1));
  endtask

  task automatic reset_cycle(input bit d);
    reset = 1'b0;
    step(d, fetch_ctl(), 1'b1);
    expect_now(d, "reset-state",
               (state_w[d] == 5'(S_FETCH)) && (mem_fault_w[d] == 1'b0) &&
               (pcwrite_w[d] == 1'b0) && (irwrite_w[d] == 1'b0) &&
               (regwrite_w[d] == 1'b0) && (memwrite_w[d] == 1'b0));
    reset = 1'b1;
  endtask

  task automatic do_instr(input bit d, input logic [5:0] o, input int fw, input int mw);
    int   k;
    ctl_t c;
    bit   f;
    op = o;
    k = find(o);
    c = fetch_ctl();
    mem_wait(d, c, fw, f);
    if (f) begin fault_tail(d); return; end
    c.irwrite = 1'b1;
    c.pcwrite = 1'b1;
    step(d, c, 1'b1);
    c = blank(S_DECODE);
    c.alusrcb = 3'b011;
    if (k < 0 || (d && tbl[k].half)) begin
      c.illegal = 1'b1;
      step(d, c, 1'($urandom));
      return;
    end
    step(d, c, 1'($urandom));
    case (tbl[k].kind)
      K_LOAD, K_STORE: begin
        c = blank(S_MEMADR); c.alusrca = 1'b1; c.alusrcb = 3'b010;
        step(d, c, 1'($urandom));
        if (tbl[k].kind == K_LOAD) begin
          c = blank(S_MEMRD); c.iord = 1'b1; c.mem_req = 1'b1; c.ldsize = tbl[k].sz;
          mem_wait(d, c, mw, f);
          if (f) begin fault_tail(d); return; end
          step(d, c, 1'b1);
          c = blank(S_MEMWB); c.regwrite = 1'b1; c.wbsel = 2'b01; c.ldsize = tbl[k].sz;
          step(d, c, 1'($urandom));
        end else begin
          c = blank(S_MEMWR); c.iord = 1'b1; c.mem_req = 1'b1; c.stsize = tbl[k].sz[1:0];
          mem_wait(d, c, mw, f);
          if (f) begin fault_tail(d); return; end
          c.memwrite = 1'b1;
          step(d, c, 1'b1);
        end
      end
      K_R: begin
        c = blank(S_RTYPEEX); c.alusrca = 1'b1; c.aluop = 3'b010;
        step(d, c, 1'($urandom));
        c = blank(S_RTYPEWB); c.regwrite = 1'b1; c.regdst = 2'b01;
        step(d, c, 1'($urandom));
      end
      K_BEQ, K_BNE: begin
        c = blank(tbl[k].kind == K_BEQ ? S_BEQEX : S_BNEEX);
        c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsrc = 2'b01;
        c.branch = (tbl[k].kind == K_BEQ);
        c.bne    = (tbl[k].kind == K_BNE);
        step(d, c, 1'($urandom));
      end
      K_IMM: begin
        c = blank(S_IMMEX); c.alusrca = 1'b1; c.alusrcb = tbl[k].srcb; c.aluop = tbl[k].alu;
        step(d, c, 1'($urandom));
        c = blank(S_IMMWB); c.regwrite = 1'b1;
        step(d, c, 1'($urandom));
      end
      K_J: begin
        c = blank(S_JEX); c.pcwrite = 1'b1; c.pcsrc = 2'b10;
        step(d, c, 1'($urandom));
      end
      default: begin
        c = blank(S_JALEX); c.pcwrite = 1'b1; c.pcsrc = 2'b10;
        c.regwrite = 1'b1; c.regdst = 2'b10; c.wbsel = 2'b10;
        step(d, c, 1'($urandom));
      end
    endcase
  endtask

  // SW whose write wait is cut short by reset, with ready arriving in the reset cycle.
  task automatic sw_reset_midwait();
    ctl_t c;
    op = 6'b101011;
    c = fetch_ctl(); c.irwrite = 1'b1; c.pcwrite = 1'b1;
    step(0, c, 1'b1);
    c = blank(S_DECODE); c.alusrcb = 3'b011;
    step(0, c, 1'b0);
    c = blank(S_MEMADR); c.alusrca = 1'b1; c.alusrcb = 3'b010;
    step(0, c, 1'b0);
    c = blank(S_MEMWR); c.iord = 1'b1; c.mem_req = 1'b1;
    step(0, c, 1'b0);
    step(0, c, 1'b0);
    reset_cycle(0);
  endtask

  function automatic logic [5:0] rand_op();
    if ($urandom_range(0, 9) < 8) return tbl[$urandom_range(0, tbl.size() - 1)].op;
    return 6'($urandom);
  endfunction

  initial begin
    tbl.push_back('{6'b100011, K_LOAD,  3'b000, 3'b000, 3'b000, 1'b0}); // LW
    tbl.push_back('{6'b100100, K_LOAD,  3'b001, 3'b000, 3'b000, 1'b0}); // LBU
    tbl.push_back('{6'b100000, K_LOAD,  3'b010, 3'b000, 3'b000, 1'b0}); // LB
    tbl.push_back('{6'b100101, K_LOAD,  3'b011, 3'b000, 3'b000, 1'b1}); // LHU
    tbl.push_back('{6'b100001, K_LOAD,  3'b100, 3'b000, 3'b000, 1'b1}); // LH
    tbl.push_back('{6'b101011, K_STORE, 3'b000, 3'b000, 3'b000, 1'b0}); // SW
    tbl.push_back('{6'b101000, K_STORE, 3'b001, 3'b000, 3'b000, 1'b0}); // SB
    tbl.push_back('{6'b101001, K_STORE, 3'b010, 3'b000, 3'b000, 1'b1}); // SH
    tbl.push_back('{6'b000000, K_R,     3'b000, 3'b000, 3'b000, 1'b0}); // R-type
    tbl.push_back('{6'b000100, K_BEQ,   3'b000, 3'b000, 3'b000, 1'b0}); // BEQ
    tbl.push_back('{6'b000101, K_BNE,   3'b000, 3'b000, 3'b000, 1'b0}); // BNE
    tbl.push_back('{6'b001000, K_IMM,   3'b000, 3'b010, 3'b000, 1'b0}); // ADDI
    tbl.push_back('{6'b001010, K_IMM,   3'b000, 3'b010, 3'b101, 1'b0}); // SLTI
    tbl.push_back('{6'b001100, K_IMM,   3'b000, 3'b100, 3'b011, 1'b0}); // ANDI
    tbl.push_back('{6'b001101, K_IMM,   3'b000, 3'b100, 3'b100, 1'b0}); // ORI
    tbl.push_back('{6'b000010, K_J,     3'b000, 3'b000, 3'b000, 1'b0}); // J
    tbl.push_back('{6'b000011, K_JAL,   3'b000, 3'b000, 3'b000, 1'b0}); // JAL

    reset = 1'b1;
    op = 6'd0;
    mem_ready = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    reset_cycle(0);

    do_instr(0, 6'b100011, 3, 2);
    do_instr(0, 6'b101001, 0, 2);
    do_instr(0, 6'b000011, 0, 0);
    do_instr(0, 6'b001101, 0, 0);
    do_instr(0, 6'b001010, 0, 0);
    do_instr(0, 6'b100011, 0, 14);
    do_instr(0, 6'b101011, 14, 1);
    do_instr(0, 6'b111111, 1, 0);
    for (int i = 0; i < 40; i++) do_instr(0, rand_op(), $urandom_range(0, 4), $urandom_range(0, 4));

    sw_reset_midwait();
    do_instr(0, 6'b000100, 0, 0);

    do_instr(0, 6'b100011, 0, 20);
    reset_cycle(0);
    do_instr(0, 6'b101000, 0, 20);
    reset_cycle(0);
    do_instr(0, 6'b000000, 20, 0);
    reset_cycle(0);
    do_instr(0, 6'b000101, 0, 0);

    reset_cycle(1);
    do_instr(1, 6'b101001, 3, 0);
    do_instr(1, 6'b100001, 0, 0);
    do_instr(1, 6'b100011, 3, 3);
    do_instr(1, 6'b101000, 2, 2);
    for (int i = 0; i < 20; i++) do_instr(1, rand_op(), $urandom_range(0, 4), $urandom_range(0, 4));

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
